// File: rtl/clock_pkg.sv
// Shared types and limits for the clock controller: FSM states, field maxima
// and a saturating-wrap increment used by every time field.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        SET_HOURS   = 2'd1,
        SET_MINUTES = 2'd2
    } state_t;

    localparam logic [5:0] MAX_HOURS   = 6'd23;
    localparam logic [5:0] MAX_MINUTES = 6'd59;
    localparam logic [5:0] MAX_SECONDS = 6'd59;

    // Using >= rather than == keeps a field in range even from a corrupted value.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] limit);
        return (value >= limit) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector; one-cycle
// press event three clocks after the key rises.
module key_edge (
    input  logic clock,
    input  logic resetN,
    input  logic key,
    output logic press
);

    logic sync_p0, sync_p1, sync_p2;
    logic vld_p0, vld_p1;
    logic armed;

    // armed only sets once a genuine low has been seen after reset, so a key held
    // through reset cannot produce a press when reset is released.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            armed   <= armed | (vld_p1 & ~sync_p1);
            press   <= armed & sync_p1 & ~sync_p2;
        end
    end

endmodule

// File: rtl/clock_controller.sv
// 24-hour clock with a seconds prescaler and a two-key set mode
// (SET_HOURS / SET_MINUTES) that blinks the digits being edited at 2 Hz.
module clock_controller
    import clock_pkg::*;
#(
    parameter int CLOCK_HZ = 50000000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       keySet,
    input  logic       keyUp,
    output logic [5:0] minutes,
    output logic [5:0] hours,
    output logic       blankMinutes,
    output logic       blankHours,
    output logic       secondPulse
);

    localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam int BW = (CLOCK_HZ / 4 > 1) ? $clog2(CLOCK_HZ / 4) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(CLOCK_HZ / 4 - 1);

    state_t        state, state_next;
    logic          set_press, up_press;
    logic          set_ev, up_ev, tick;
    logic [PW-1:0] presc, presc_d;
    logic [5:0]    seconds, seconds_d, minutes_d, hours_d;
    logic [BW-1:0] blink_cnt, blink_cnt_d;
    logic          phase, phase_d;
    logic          pulse_d, blank_hours_d, blank_minutes_d;

    key_edge u_key_set (.clock(clock), .resetN(resetN), .key(keySet), .press(set_press));
    key_edge u_key_up  (.clock(clock), .resetN(resetN), .key(keyUp),  .press(up_press));

    assign set_ev = set_press;
    assign up_ev  = up_press & ~set_press;
    assign tick   = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= RUN;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:         if (set_ev) state_next = SET_HOURS;
            SET_HOURS:   if (set_ev) state_next = SET_MINUTES;
            SET_MINUTES: if (set_ev) state_next = RUN;
            default:     state_next = RUN;
        endcase
    end

    // Time-keeping datapath: counting in RUN, editing in the set states.
    always_comb begin
        presc_d   = presc;
        seconds_d = seconds;
        minutes_d = minutes;
        hours_d   = hours;
        pulse_d   = 1'b0;
        case (state)
            RUN: begin
                pulse_d = tick;
                if (tick) begin
                    presc_d   = '0;
                    seconds_d = wrap_inc(seconds, MAX_SECONDS);
                    if (seconds >= MAX_SECONDS) begin
                        minutes_d = wrap_inc(minutes, MAX_MINUTES);
                        if (minutes >= MAX_MINUTES) hours_d = wrap_inc(hours, MAX_HOURS);
                    end
                end else begin
                    presc_d = presc + 1'b1;
                end
            end
            SET_HOURS: if (up_ev) hours_d = wrap_inc(hours, MAX_HOURS);
            SET_MINUTES: begin
                if (set_ev) begin
                    presc_d   = '0;
                    seconds_d = '0;
                end else if (up_ev) begin
                    minutes_d = wrap_inc(minutes, MAX_MINUTES);
                end
            end
            default: ;
        endcase
    end

    // Blink phase restarts from 0 whenever a set state is entered.
    always_comb begin
        blink_cnt_d     = '0;
        phase_d         = 1'b0;
        if (state_next != RUN && state_next != state) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (state != RUN) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase;
            end else begin
                blink_cnt_d = blink_cnt + 1'b1;
                phase_d     = phase;
            end
        end
        blank_hours_d   = (state_next == SET_HOURS)   & phase_d;
        blank_minutes_d = (state_next == SET_MINUTES) & phase_d;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            presc        <= '0;
            seconds      <= '0;
            minutes      <= '0;
            hours        <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
            secondPulse  <= 1'b0;
            blankHours   <= 1'b0;
            blankMinutes <= 1'b0;
        end else begin
            presc        <= presc_d;
            seconds      <= seconds_d;
            minutes      <= minutes_d;
            hours        <= hours_d;
            blink_cnt    <= blink_cnt_d;
            phase        <= phase_d;
            secondPulse  <= pulse_d;
            blankHours   <= blank_hours_d;
            blankMinutes <= blank_minutes_d;
        end
    end

endmodule
